// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register of a 5-stage core.
// Holds the PC, issues one fetch request per cycle to instruction memory and
// captures the returned instruction into IF/ID. Redirects (branch from EX,
// jump from ID) that arrive while a fetch is still outstanding are parked in
// saved_target and applied once that old fetch finally completes (DRAIN).
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   PC_write, IFID_write   : hazard-unit enables (0 = stall)
//   IFID_flush             : hazard-unit clear of IF/ID
//   Branch2, BranchAddr    : taken branch resolved in EX and its target
//   Jump, JumpAddr         : jump decoded in ID and its target
//   imem_req, imem_addr    : fetch request / address (address = PC)
//   imem_rdata, imem_ready : returned instruction, fetch completes this cycle
//   IFID_PC4, IFID_Instr   : registered PC+4 and instruction
//   IFID_valid             : IF/ID holds a real instruction
//   fetch_stall            : fetch is not completing this cycle
//   dbg_state              : FSM state (0 = FETCH, 1 = DRAIN)
//
// Handshake: the request is held (imem_req=1, imem_addr unchanged) from the
// cycle it is raised until the cycle imem_ready=1; that cycle's imem_rdata is
// the response, and the next request starts on the following cycle.
// ----------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        IFID_write,
    input  logic        IFID_flush,
    input  logic        Branch2,
    input  logic [31:0] BranchAddr,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IFID_PC4,
    output logic [31:0] IFID_Instr,
    output logic        IFID_valid,
    output logic        fetch_stall,
    output logic        dbg_state
);

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] saved_target_q, saved_target_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        unused_addr_bits;

    // Targets are word aligned; their low two bits are ignored.
    assign redirect         = Branch2 | Jump;
    assign target           = Branch2 ? {BranchAddr[31:2], 2'b00}
                                      : {JumpAddr[31:2], 2'b00};
    assign unused_addr_bits = ^{BranchAddr[1:0], JumpAddr[1:0]};
    assign pc_plus4         = pc_q + 32'd4;

    // An instruction is only kept if the PC moves past it this cycle. When the
    // PC is held it will be refetched, so capturing it now would duplicate it.
    assign advance = (state_q == FETCH) && imem_ready && (redirect || PC_write);

    // ------------------------------------------------------------------------
    // Next-state / PC logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        saved_target_d = saved_target_q;
        if (state_q == FETCH) begin
            if (imem_ready) begin
                if (redirect) begin
                    pc_d = target;
                end else if (PC_write) begin
                    pc_d = pc_plus4;
                end
            end else if (redirect) begin
                // The outstanding fetch must still be allowed to finish at
                // the old address, so park the target.
                saved_target_d = target;
                state_d        = DRAIN;
            end
        end else begin
            if (redirect) begin
                saved_target_d = target;
            end
            if (imem_ready) begin
                // A redirect arriving in the completing cycle is the newest.
                pc_d    = redirect ? target : saved_target_q;
                state_d = FETCH;
            end
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID register next value
    // ------------------------------------------------------------------------
    always_comb begin
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (IFID_flush) begin
            ifid_pc4_d   = 32'd0;
            ifid_instr_d = 32'd0;
            ifid_valid_d = 1'b0;
        end else if (IFID_write) begin
            if (advance) begin
                ifid_pc4_d   = pc_plus4;
                ifid_instr_d = imem_rdata;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_pc4_d   = 32'd0;
                ifid_instr_d = 32'd0;
                ifid_valid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FETCH;
            pc_q           <= {RESET_PC[31:2], 2'b00};
            saved_target_q <= 32'd0;
            ifid_pc4_q     <= 32'd0;
            ifid_instr_q   <= 32'd0;
            ifid_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            saved_target_q <= saved_target_d;
            ifid_pc4_q     <= ifid_pc4_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_valid_q   <= ifid_valid_d;
        end
    end

    assign imem_req    = ~reset;
    assign imem_addr   = pc_q;
    assign fetch_stall = ~reset & ((state_q == DRAIN) | ~imem_ready);
    assign IFID_PC4    = ifid_pc4_q;
    assign IFID_Instr  = ifid_instr_q;
    assign IFID_valid  = ifid_valid_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PC_write  input  1  hazard-unit PC write enable.
REQ-005 SHALL have port IFID_write  input  1  hazard-unit IF/ID write enable.
REQ-006 SHALL have port IFID_flush  input  1  hazard-unit IF/ID clear.
REQ-007 SHALL have port Branch2  input  1  taken branch resolved in EX.
REQ-008 SHALL have port BranchAddr  input  32  branch target.
REQ-009 SHALL have port Jump  input  1  jump decoded in ID.
REQ-010 SHALL have port JumpAddr  input  32  jump target.
REQ-011 SHALL have port imem_req  output  1  instruction fetch request.
REQ-012 SHALL have port imem_addr  output  32  fetch address.
REQ-013 SHALL have port imem_rdata  input  32  fetched instruction, valid when imem_ready=1.
REQ-014 SHALL have port imem_ready  input  1  fetch completes this cycle.
REQ-015 SHALL have port IFID_PC4  output  32  registered PC+4 of held instruction.
REQ-016 SHALL have port IFID_Instr  output  32  registered instruction.
REQ-017 SHALL have port IFID_valid  output  1  IF/ID holds a real instruction.
REQ-018 SHALL have port fetch_stall  output  1  fetch not completing this cycle.

Function
REQ-019 SHALL hold a 32-bit PC with PC[1:0] always 00; target low two bits ignored.
REQ-020 SHALL drive imem_addr=PC and imem_req=1 whenever reset=0; imem_addr stable while imem_req=1 and imem_ready=0.
REQ-021 SHALL implement FSM states FETCH and DRAIN.
REQ-022 SHALL select redirect target: Branch2=1 -> BranchAddr, else Jump=1 -> JumpAddr (Branch2 wins on tie); redirect overrides PC_write=0.
REQ-023 SHALL in FETCH with imem_ready=1: redirect -> PC=target; else PC_write=1 -> PC=PC+4; else hold.
REQ-024 SHALL in FETCH with imem_ready=0: redirect -> latch target into saved_target, go DRAIN, PC held; else hold PC.
REQ-025 SHALL in DRAIN keep requesting old PC; on imem_ready=1 -> PC=saved_target, discard data, go FETCH.
REQ-026 SHALL in DRAIN overwrite saved_target on any new redirect (same priority).
REQ-027 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-028 SHALL update IF/ID by priority: IFID_flush=1 -> bubble; else IFID_write=0 -> hold; else FETCH and imem_ready=1 -> load imem_rdata, PC+4, valid=1; else bubble.
REQ-029 SHALL define bubble as IFID_Instr=0, IFID_PC4=0, IFID_valid=0.
REQ-030 SHALL drop an instruction completing while IFID_write=0 or PC_write=0 with no redirect; PC held so it is refetched.
REQ-031 SHALL assert fetch_stall = (state==DRAIN) | (imem_ready==0), combinationally; 0 during reset.
REQ-032 SHALL give one-cycle latency: instruction returned at edge N appears on IFID_* after edge N.

Reset
REQ-033 SHALL on reset=1 at an edge set PC=RESET_PC, state=FETCH, saved_target=0, IF/ID=bubble, from any state including DRAIN.
REQ-034 SHALL hold imem_req=0 while reset=1.

Verification
REQ-035 SHALL cover sequential fetch: imem_ready=1, enables 1, 3 cycles -> IFID_PC4=0x80000004,0x80000008,0x8000000C, valid=1.
REQ-036 SHALL cover load-use stall: PC_write=0, IFID_write=0 for 1 cycle at PC=0x80000008 -> PC and IF/ID held, same address refetched next cycle.
REQ-037 SHALL cover redirect priority: Branch2=1 BranchAddr=0x80000100, Jump=1 JumpAddr=0x80000200, IFID_flush=1 -> PC=0x80000100, IF/ID bubble.
REQ-038 SHALL cover DRAIN: imem_ready=0, Jump=1 JumpAddr=0x80000040 -> imem_addr stable, fetch_stall=1; ready next cycle -> data discarded, PC=0x80000040, no valid instruction.
REQ-039 SHALL cover wrap and reset: PC=0xFFFFFFFC fetch -> IFID_PC4=0, PC=0; reset in DRAIN -> PC=0x80000000, FETCH, valid=0.
